shift_ex_stage: RTL and testbench
=================================

// Module: shift_ex_stage
// PURPOSE
//  Execute-stage wrapper for shift instructions (SLL/SRA/ROR) in the 16-bit CPU.
//  Accepts decoded ops from ID/EX, drives the Shifter datapath, buffers results in a 2-entry skid queue,
//  and hands them to the writeback stage under valid/ready. Owns the architectural Z flag for shifts.
// PARAMETERS
//  DW        16   datapath width; only 16 is supported
//  OPC_SLL   4'h4 opcode that selects logical shift left
//  OPC_SRA   4'h5 opcode that selects arithmetic shift right
//  OPC_ROR   4'h6 opcode that selects rotate right
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  flush      in   1   synchronous squash of every buffered entry
//  in_valid   in   1   upstream op valid
//  in_ready   out  1   stage can accept an op this cycle
//  in_opcode  in   4   instruction opcode
//  in_src     in   16  rs operand value
//  in_imm     in   4   shift amount, 0..15
//  in_dst     in   4   destination register index
//  out_valid  out  1   result entry valid
//  out_ready  in   1   writeback accepts the entry
//  out_result out  16  shifted value
//  out_dst    out  4   destination register index
//  out_wen    out  1   1 = write the register file; 0 = illegal op, do not write
//  z_flag     out  1   architectural zero flag
// BEHAVIOUR
//  Reset (async, rst_n=0): queue empty; out_valid=0, out_result=0, out_dst=0, out_wen=0, z_flag=0, in_ready=1.
//  Decode (combinational on the input):
//   - OPC_SLL -> Mode 2'b00, result = src << imm.
//   - OPC_SRA -> Mode 2'b01, result = $signed(src) >>> imm.
//   - OPC_ROR -> Mode 2'b10, result = (src >> imm) | (src << (16-imm)).
//   - imm=0 passes src through unchanged for all three ops.
//   - Any other opcode is accepted as illegal: result=0, wen=0.
//  Accept rule: op accepted when in_valid && in_ready. Computed result, dst and wen are captured into the queue tail.
//  Latency: 1 cycle. An op accepted in cycle N into an empty queue shows out_valid=1 in cycle N+1.
//  Queue: 2 entries, FIFO order. in_ready = (count<2) | (count==2 & out_ready).
//   - in_ready is registered-path friendly: it depends only on count and out_ready.
//   - Simultaneous push+pop keeps count unchanged, including when full.
//  Drain rule: head retires when out_valid && out_ready. out_* stay stable while out_valid && !out_ready.
//  Z flag: on each retire with wen=1, z_flag <= (out_result==16'h0000). Illegal ops never change z_flag.
//  Flush: next cycle count=0 and out_valid=0. The input op presented in the flush cycle is dropped.
//   - z_flag is not updated by any entry retiring in the flush cycle; flush wins over retire.
//  Reset mid-operation: all entries are discarded immediately; no partial retire occurs.
//  No X propagation: when out_valid=0, out_result, out_dst and out_wen hold 0.
// STRUCTURE
//  Shared package cpu_pkg: opcode localparams (OPC_SLL/SRA/ROR), shift Mode encodings
//   (SHM_SLL=2'b00, SHM_SRA=2'b01, SHM_ROR=2'b10), result entry struct {result[15:0], dst[3:0], wen}.
//  Sub-module: shift_skid_buf, the 2-entry FIFO with count and valid/ready logic, parameterised on entry width (21).
//  Shifter datapath instantiated once on the input side, between decode and the queue tail.
// TESTING
//  1. SLL src=0x8001 imm=1, out_ready=1 -> next cycle out_result=0x0002, wen=1; after retire z_flag=0.
//  2. SRA src=0x8000 imm=15 -> 0xFFFF; ROR src=0x0001 imm=4 -> 0x1000; SLL src=0x8000 imm=1 -> 0x0000 with z_flag=1 after retire.
//  3. Backpressure: out_ready=0, push 3 ops back to back.
//   - in_ready drops to 0 after 2 accepted; 3rd held at input.
//   - Raise out_ready -> results retire in order and the 3rd op is then accepted.
//  4. Opcode 4'hA, src=0x1234 -> out_wen=0, out_result=0; z_flag unchanged from its prior value (set to 1 first).
//  5. Full queue plus flush while in_valid=1 -> next cycle out_valid=0, in_ready=1, no z_flag change, input op dropped.
//  6. rst_n pulsed low asynchronously mid-clock with 2 entries queued -> outputs zero immediately, z_flag=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the shift execute stage: opcodes, shifter modes,
// the queued result entry and the shifter datapath itself.
package cpu_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned OPC_W = 4;
    localparam int unsigned REG_W = 4;
    localparam int unsigned AMT_W = 4;

    localparam logic [OPC_W-1:0] OPC_SLL = 4'h4;
    localparam logic [OPC_W-1:0] OPC_SRA = 4'h5;
    localparam logic [OPC_W-1:0] OPC_ROR = 4'h6;

    localparam logic [1:0] SHM_SLL = 2'b00;
    localparam logic [1:0] SHM_SRA = 2'b01;
    localparam logic [1:0] SHM_ROR = 2'b10;
    localparam logic [1:0] SHM_ILL = 2'b11;

    typedef struct packed {
        logic [DW-1:0]    result;
        logic [REG_W-1:0] dst;
        logic             wen;
    } shift_entry_t;

    localparam int unsigned ENTRY_W = $bits(shift_entry_t);

    // Rotate uses a doubled operand so imm=0 needs no special case.
    function automatic logic [DW-1:0] shift_apply(input logic [1:0]       mode,
                                                  input logic [DW-1:0]    src,
                                                  input logic [AMT_W-1:0] amt);
        logic [2*DW-1:0] dbl;
        logic [2*DW-1:0] rot;
        logic [DW-1:0]   res;
        dbl = {src, src};
        rot = dbl >> amt;
        res = '0;
        case (mode)
            SHM_SLL: res = src << amt;
            SHM_SRA: res = DW'($signed(src) >>> amt);
            SHM_ROR: res = rot[DW-1:0];
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shift_skid_buf.sv
// Two-entry FIFO between the shifter and writeback; slot 0 is always the head,
// so the head is presented straight from a register and idles at zero.
module shift_skid_buf #(
    parameter int unsigned W = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] data_o
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic         pop;

    assign out_valid_o = (count_q != 2'd0);
    assign in_ready_o  = (count_q != 2'd2) | out_ready_i;
    assign data_o      = ent0_q;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        if (flush_i) begin
            count_d = 2'd0;
            ent0_d  = '0;
            ent1_d  = '0;
        end else if (push_i && pop) begin
            // Count stays put; the new entry lands behind whatever remains.
            if (count_q == 2'd2) begin
                ent0_d = ent1_q;
                ent1_d = data_i;
            end else begin
                ent0_d = data_i;
            end
        end else if (pop) begin
            ent0_d  = (count_q == 2'd2) ? ent1_q : '0;
            ent1_d  = '0;
            count_d = count_q - 2'd1;
        end else if (push_i) begin
            if (count_q == 2'd0) begin
                ent0_d = data_i;
            end else begin
                ent1_d = data_i;
            end
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

endmodule

// File: rtl/shift_ex_stage.sv
// Execute stage for SLL/SRA/ROR: decode, shift, queue results for writeback
// and maintain the architectural zero flag on retirement.
module shift_ex_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [15:0] in_src,
    input  logic [3:0]  in_imm,
    input  logic [3:0]  in_dst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [3:0]  out_dst,
    output logic        out_wen,
    output logic        z_flag
);

    logic [1:0]   mode_c;
    logic         legal_c;
    logic         push;
    logic         retire;
    logic         z_q, z_d;
    shift_entry_t in_entry;
    shift_entry_t head;

    always_comb begin
        mode_c  = SHM_ILL;
        legal_c = 1'b1;
        case (in_opcode)
            OPC_SLL: mode_c = SHM_SLL;
            OPC_SRA: mode_c = SHM_SRA;
            OPC_ROR: mode_c = SHM_ROR;
            default: legal_c = 1'b0;
        endcase
    end

    always_comb begin
        in_entry        = '0;
        in_entry.result = legal_c ? shift_apply(mode_c, in_src, in_imm) : 16'h0000;
        in_entry.dst    = in_dst;
        in_entry.wen    = legal_c;
    end

    assign push = in_valid & in_ready & ~flush;

    shift_skid_buf #(
        .W (ENTRY_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .push_i      (push),
        .data_i      (in_entry),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (head)
    );

    assign out_result = head.result;
    assign out_dst    = head.dst;
    assign out_wen    = head.wen;

    // A flush squashes the head even if writeback accepts it that cycle.
    assign retire = out_valid & out_ready & ~flush;

    always_comb begin
        z_d = z_q;
        if (retire && head.wen) begin
            z_d = (head.result == 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
        end else begin
            z_q <= z_d;
        end
    end

    assign z_flag = z_q;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed self-checking bench for shift_ex_stage.
module tb_shift_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [15:0] in_src;
    logic [3:0]  in_imm;
    logic [3:0]  in_dst;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_dst;
    logic        out_wen;
    logic        z_flag;

    int checks;
    int errors;

    shift_ex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_src     (in_src),
        .in_imm     (in_imm),
        .in_dst     (in_dst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dst    (out_dst),
        .out_wen    (out_wen),
        .z_flag     (z_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] opc, input logic [15:0] src,
                         input logic [3:0] imm, input logic [3:0] dst);
        in_valid  = v;
        in_opcode = opc;
        in_src    = src;
        in_imm    = imm;
        in_dst    = dst;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 4'h0, 16'h0000, 4'h0, 4'h0);
        #12;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_result", 32'(out_result), 32'h0);
        check("rst_dst", 32'(out_dst), 32'h0);
        check("rst_wen", 32'(out_wen), 32'h0);
        check("rst_z", 32'(z_flag), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        tick();

        // SLL 0x8001 by 1
        drive(1'b1, 4'h4, 16'h8001, 4'd1, 4'd3);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 4'd0, 4'd0);
        check("sll_valid", 32'(out_valid), 32'h1);
        check("sll_result", 32'(out_result), 32'h0002);
        check("sll_dst", 32'(out_dst), 32'h3);
        check("sll_wen", 32'(out_wen), 32'h1);
        tick();
        check("sll_z", 32'(z_flag), 32'h0);
        check("sll_drained", 32'(out_valid), 32'h0);

        // SRA, then ROR pushed while SRA retires, then SLL to zero
        drive(1'b1, 4'h5, 16'h8000, 4'd15, 4'd1);
        tick();
        check("sra_result", 32'(out_result), 32'hFFFF);
        drive(1'b1, 4'h6, 16'h0001, 4'd4, 4'd2);
        tick();
        check("ror_result", 32'(out_result), 32'h1000);
        check("ror_dst", 32'(out_dst), 32'h2);
        check("sra_z", 32'(z_flag), 32'h0);
        drive(1'b1, 4'h4, 16'h8000, 4'd1, 4'd4);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 4'd0, 4'd0);
        check("sll0_result", 32'(out_result), 32'h0000);
        check("sll0_wen", 32'(out_wen), 32'h1);
        tick();
        check("sll0_z", 32'(z_flag), 32'h1);

        // Illegal opcode leaves z_flag at 1
        drive(1'b1, 4'hA, 16'h1234, 4'd3, 4'd7);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 4'd0, 4'd0);
        check("ill_valid", 32'(out_valid), 32'h1);
        check("ill_wen", 32'(out_wen), 32'h0);
        check("ill_result", 32'(out_result), 32'h0000);
        tick();
        check("ill_z", 32'(z_flag), 32'h1);

        // Backpressure: three ops, only two fit
        out_ready = 1'b0;
        drive(1'b1, 4'h4, 16'h0001, 4'd2, 4'd1);
        tick();
        check("bp_ready1", 32'(in_ready), 32'h1);
        drive(1'b1, 4'h5, 16'h00F0, 4'd4, 4'd2);
        tick();
        check("bp_ready2", 32'(in_ready), 32'h0);
        check("bp_head", 32'(out_result), 32'h0004);
        drive(1'b1, 4'h6, 16'h0003, 4'd1, 4'd5);
        tick();
        check("bp_held_ready", 32'(in_ready), 32'h0);
        check("bp_stable", 32'(out_result), 32'h0004);
        check("bp_stable_dst", 32'(out_dst), 32'h1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 4'd0, 4'd0);
        check("bp_second", 32'(out_result), 32'h000F);
        check("bp_second_dst", 32'(out_dst), 32'h2);
        tick();
        check("bp_third", 32'(out_result), 32'h8001);
        check("bp_third_dst", 32'(out_dst), 32'h5);
        tick();
        check("bp_empty", 32'(out_valid), 32'h0);
        check("bp_z", 32'(z_flag), 32'h0);

        // Set z_flag, fill queue, then flush with a live input op
        drive(1'b1, 4'h4, 16'h8000, 4'd1, 4'd0);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 4'd0, 4'd0);
        tick();
        check("fl_z_pre", 32'(z_flag), 32'h1);
        out_ready = 1'b0;
        drive(1'b1, 4'h4, 16'h0001, 4'd0, 4'd6);
        tick();
        check("imm0_pass", 32'(out_result), 32'h0001);
        drive(1'b1, 4'h6, 16'hABCD, 4'd0, 4'd7);
        tick();
        check("fl_full", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 4'h5, 16'h1111, 4'd1, 4'd8);
        tick();
        flush = 1'b0;
        drive(1'b0, 4'h0, 16'h0000, 4'd0, 4'd0);
        check("fl_valid", 32'(out_valid), 32'h0);
        check("fl_ready", 32'(in_ready), 32'h1);
        check("fl_result", 32'(out_result), 32'h0);
        check("fl_z", 32'(z_flag), 32'h1);
        tick();
        check("fl_dropped", 32'(out_valid), 32'h0);

        // Async reset with two entries queued
        out_ready = 1'b0;
        drive(1'b1, 4'h4, 16'h00FF, 4'd4, 4'd9);
        tick();
        drive(1'b1, 4'h6, 16'h0F0F, 4'd4, 4'd10);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 4'd0, 4'd0);
        check("ar_pre_valid", 32'(out_valid), 32'h1);
        check("ar_pre_result", 32'(out_result), 32'h0FF0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'h0);
        check("ar_result", 32'(out_result), 32'h0);
        check("ar_dst", 32'(out_dst), 32'h0);
        check("ar_wen", 32'(out_wen), 32'h0);
        check("ar_z", 32'(z_flag), 32'h0);
        check("ar_ready", 32'(in_ready), 32'h1);
        #3;
        rst_n = 1'b1;
        tick();
        check("ar_post_valid", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
